// File: rtl/e1_tx_mf_feeder.sv
// E1 TX multiframe feeder: binds host-submitted multiframe buffer descriptors to
// transmitted multiframes and serves the framer's per-timeslot byte fetches from RAM.
module e1_tx_mf_feeder #(
  parameter int MF_W       = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        fr_frame,
  input  logic [4:0]        fr_ts,
  input  logic              fr_mf_first,
  input  logic              fr_mf_last,
  input  logic              fr_req,
  output logic [7:0]        fr_data,
  output logic [1:0]        fr_crc_e,
  output logic              fr_rdy,
  output logic [MF_W+8:0]   buf_rd_addr,
  output logic              buf_rd_en,
  input  logic [7:0]        buf_rd_data,
  input  logic              sub_valid,
  input  logic [MF_W-1:0]   sub_mf,
  output logic              sub_ready,
  output logic              done_valid,
  output logic [MF_W-1:0]   done_mf,
  input  logic              ctrl_enable,
  input  logic [1:0]        ctrl_crc_e,
  input  logic              ctrl_uf_clr,
  output logic [15:0]       stat_uf_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a descriptor transfers on any clock edge where sub_valid & sub_ready;
  // sub_ready depends only on FIFO fullness, never on sub_valid.

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_UNDERRUN = 2'd2
  } state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  // Descriptor FIFO
  logic [MF_W-1:0]     fifo_mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic                fifo_full, fifo_empty, push, pop;

  // Control and pipeline state
  state_t              state_q, state_d;
  logic [MF_W-1:0]     cur_mf_q, cur_mf_d;
  logic [15:0]         uf_cnt_q, uf_cnt_d;
  logic [1:0]          crc_e_q;
  logic                rd_en_q, rd_en_d, rd_pend_q;
  logic [MF_W+8:0]     rd_addr_q;
  logic [7:0]          data_q;
  logic                rdy_q;
  logic                done_q, done_d;
  logic [MF_W-1:0]     done_mf_q;
  logic                eval;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = fifo_cnt[DEPTH_LOG2];
  assign fifo_empty = (fifo_cnt == '0);
  assign sub_ready  = ~fifo_full;
  assign push       = sub_valid & ~fifo_full;
  assign eval       = fr_req & fr_mf_first;
  assign pop        = eval & ctrl_enable & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= sub_mf;
  end

  always_comb begin
    state_d  = state_q;
    cur_mf_d = cur_mf_q;
    uf_cnt_d = uf_cnt_q;
    done_d   = 1'b0;
    if (eval) begin
      if (ctrl_enable && !fifo_empty) begin
        state_d  = ST_ACTIVE;
        cur_mf_d = fifo_mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end else if (ctrl_enable) begin
        state_d = ST_UNDERRUN;
        if (uf_cnt_q != 16'hffff) uf_cnt_d = uf_cnt_q + 16'd1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (fr_req && fr_mf_last) begin
      done_d  = (state_q == ST_ACTIVE);
      state_d = ST_IDLE;
    end
    if (ctrl_uf_clr) uf_cnt_d = 16'd0;
    // The last request of a multiframe still reads under the state it arrived in.
    rd_en_d = fr_req & (eval ? (state_d == ST_ACTIVE) : (state_q == ST_ACTIVE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= ST_IDLE;
      cur_mf_q  <= '0;
      uf_cnt_q  <= 16'd0;
      crc_e_q   <= 2'b11;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= 8'hff;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      done_mf_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      state_q   <= state_d;
      cur_mf_q  <= cur_mf_d;
      uf_cnt_q  <= uf_cnt_d;
      if (eval) crc_e_q <= ctrl_crc_e;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_en_q;
      if (rd_en_d) rd_addr_q <= {cur_mf_d, fr_frame, fr_ts};
      // A new request clears the previous byte; RAM data lands two cycles later.
      if (fr_req) begin
        rdy_q  <= 1'b0;
        data_q <= 8'hff;
      end else if (rd_pend_q) begin
        rdy_q  <= 1'b1;
        data_q <= buf_rd_data;
      end
      done_q <= done_d;
      if (done_d) done_mf_q <= cur_mf_q;
    end
  end

  assign fr_data     = data_q;
  assign fr_crc_e    = crc_e_q;
  assign fr_rdy      = rdy_q;
  assign buf_rd_addr = rd_addr_q;
  assign buf_rd_en   = rd_en_q;
  assign done_valid  = done_q;
  assign done_mf     = done_mf_q;
  assign stat_uf_cnt = uf_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_e1_tx_mf_feeder.sv
// Directed bench for e1_tx_mf_feeder: reference model of the descriptor FIFO and
// multiframe FSM, with a scoreboard of expected read addresses, bytes and completions.
module tb_e1_tx_mf_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fr_frame;
  logic [4:0]  fr_ts;
  logic        fr_mf_first, fr_mf_last, fr_req;
  logic [7:0]  fr_data;
  logic [1:0]  fr_crc_e;
  logic        fr_rdy;
  logic [12:0] buf_rd_addr;
  logic        buf_rd_en;
  logic [7:0]  buf_rd_data = 8'h00;
  logic        sub_valid;
  logic [3:0]  sub_mf;
  logic        sub_ready;
  logic        done_valid;
  logic [3:0]  done_mf;
  logic        ctrl_enable;
  logic [1:0]  ctrl_crc_e;
  logic        ctrl_uf_clr;
  logic [15:0] stat_uf_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model
  int          m_state;
  logic [3:0]  m_q[$];
  logic [3:0]  m_cur;
  logic [15:0] m_uf;
  logic [1:0]  m_crc;

  // Scoreboard queues
  logic [7:0]  exp_q[$];
  logic [12:0] addr_q[$];
  logic [3:0]  done_q[$];

  e1_tx_mf_feeder #(.MF_W(4), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .fr_frame(fr_frame), .fr_ts(fr_ts), .fr_mf_first(fr_mf_first), .fr_mf_last(fr_mf_last),
    .fr_req(fr_req), .fr_data(fr_data), .fr_crc_e(fr_crc_e), .fr_rdy(fr_rdy),
    .buf_rd_addr(buf_rd_addr), .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data),
    .sub_valid(sub_valid), .sub_mf(sub_mf), .sub_ready(sub_ready),
    .done_valid(done_valid), .done_mf(done_mf),
    .ctrl_enable(ctrl_enable), .ctrl_crc_e(ctrl_crc_e), .ctrl_uf_clr(ctrl_uf_clr),
    .stat_uf_cnt(stat_uf_cnt), .dbg_state(dbg_state)
  );

  // Clock and RAM (RAM[addr] = addr[7:0], one-cycle read latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= buf_rd_addr[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_cur   = 4'd0;
    m_uf    = 16'd0;
    m_crc   = 2'b11;
  endtask

  task automatic check_reset_outputs();
    chk("rst_fr_rdy", fr_rdy, 0);
    chk("rst_fr_data", fr_data, 8'hff);
    chk("rst_crc_e", fr_crc_e, 2'b11);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_mf", done_mf, 0);
    chk("rst_uf_cnt", stat_uf_cnt, 0);
    chk("rst_sub_ready", sub_ready, 1);
    chk("rst_state", dbg_state, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 eight cycles later.
  task automatic do_req(input logic [3:0] f, input logic [4:0] t, input logic first, input logic last);
    logic act, exp_done;
    logic [7:0] ed;
    exp_done = 1'b0;
    if (first) begin
      m_crc = ctrl_crc_e;
      if (ctrl_enable && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_state = 1;
      end else if (ctrl_enable) begin
        m_state = 2;
        if (m_uf != 16'hffff) m_uf = m_uf + 16'd1;
      end else begin
        m_state = 0;
      end
      act = (m_state == 1);
    end else begin
      act = (m_state == 1);
      if (last) begin
        exp_done = (m_state == 1);
        if (exp_done) done_q.push_back(m_cur);
        m_state = 0;
      end
    end
    if (ctrl_uf_clr) m_uf = 16'd0;
    if (act) addr_q.push_back({m_cur, f, t});
    exp_q.push_back(act ? {f[2:0], t} : 8'hff);

    fr_frame = f; fr_ts = t; fr_mf_first = first; fr_mf_last = last; fr_req = 1'b1;
    @(posedge clk); #1;
    fr_req = 1'b0; fr_mf_first = 1'b0; fr_mf_last = 1'b0;
    chk("rd_en", buf_rd_en, act);
    if (act) chk("rd_addr", buf_rd_addr, addr_q.pop_front());
    chk("rdy_c1", fr_rdy, 0);
    chk("done_valid", done_valid, exp_done);
    if (exp_done) chk("done_mf", done_mf, done_q.pop_front());
    chk("crc_e", fr_crc_e, m_crc);
    chk("uf_cnt", stat_uf_cnt, m_uf);
    chk("state", dbg_state, m_state);
    @(posedge clk); #1;
    chk("rd_en_pulse", buf_rd_en, 0);
    chk("done_pulse", done_valid, 0);
    chk("rdy_c2", fr_rdy, 0);
    @(posedge clk); #1;
    ed = exp_q.pop_front();
    chk("fr_rdy", fr_rdy, act);
    chk("fr_data", fr_data, ed);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic submit(input logic [3:0] mf);
    sub_mf = mf;
    sub_valid = 1'b1;
    chk("sub_ready", sub_ready, m_q.size() < 4);
    if (m_q.size() < 4) m_q.push_back(mf);
    @(posedge clk); #1;
    sub_valid = 1'b0;
  endtask

  // hook: 1 submit mf 5, 2 crc_e -> 01, 3 drop enable, 4 stop before request hook_at
  task automatic run_mf(input int n, input int hook_at, input int hook);
    logic [8:0] ii;
    int tt;
    for (int i = 0; i < n; i++) begin
      if (i == hook_at) begin
        if (hook == 4) break;
        if (hook == 1) submit(4'd5);
        if (hook == 2) ctrl_crc_e = 2'b01;
        if (hook == 3) ctrl_enable = 1'b0;
      end
      ii = i[8:0];
      tt = (i * 7) % 32;
      if (n == 512) do_req(ii[8:5], ii[4:0], i == 0, i == n - 1);
      else          do_req(ii[3:0], tt[4:0], i == 0, i == n - 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    fr_frame = 4'd0; fr_ts = 5'd0; fr_mf_first = 1'b0; fr_mf_last = 1'b0; fr_req = 1'b0;
    sub_valid = 1'b0; sub_mf = 4'd0;
    ctrl_enable = 1'b0; ctrl_crc_e = 2'b11; ctrl_uf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #1;

    // Full multiframe from buffer 3
    ctrl_enable = 1'b1;
    submit(4'd3);
    run_mf(512, -1, 0);

    // Underrun, with mf 5 submitted mid-multiframe and used at the next mf_first
    run_mf(16, 6, 1);
    chk("uf_after_underrun", stat_uf_cnt, 16'd1);
    run_mf(16, -1, 0);

    // Fill the FIFO, fifth submission refused, then drain in order
    submit(4'd1); submit(4'd2); submit(4'd3); submit(4'd4);
    chk("fifo_full_ready", sub_ready, 0);
    submit(4'd6);
    repeat (4) run_mf(16, -1, 0);

    // E bits only follow ctrl_crc_e at mf_first
    submit(4'd7);
    run_mf(16, 5, 2);
    submit(4'd8);
    run_mf(16, -1, 0);

    // Enable dropped mid-multiframe: current completes, next stays idle
    submit(4'd9); submit(4'd10);
    run_mf(16, 7, 3);
    run_mf(16, -1, 0);
    ctrl_enable = 1'b1;

    // Reset in the middle of an active multiframe
    run_mf(16, 9, 4);
    submit(4'd11);
    rst = 1'b1;
    #2;
    check_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_mf(16, -1, 0);

    // Counter saturation, then clear racing an increment
    fr_frame = 4'd0; fr_ts = 5'd0; fr_mf_first = 1'b1; fr_req = 1'b1;
    repeat (65535 - int'(m_uf)) @(posedge clk);
    #1;
    fr_req = 1'b0; fr_mf_first = 1'b0;
    m_uf = 16'hffff; m_state = 2; m_crc = ctrl_crc_e;
    chk("uf_saturated", stat_uf_cnt, 16'hffff);
    repeat (8) @(posedge clk);
    #1;
    do_req(4'd0, 5'd0, 1'b1, 1'b0);
    chk("uf_stays_sat", stat_uf_cnt, 16'hffff);
    ctrl_uf_clr = 1'b1;
    do_req(4'd0, 5'd0, 1'b1, 1'b0);
    ctrl_uf_clr = 1'b0;
    chk("uf_clr_priority", stat_uf_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
